// File: rtl/tm1638_pkg.sv
// Shared constants, command field positions and state types for the TM1638 responder.
package tm1638_pkg;

    // Canonical command bytes as sent by a typical host
    localparam logic [7:0] C_WRITE = 8'h40;
    localparam logic [7:0] C_READ  = 8'h42;
    localparam logic [7:0] C_ADDR  = 8'hC0;
    localparam logic [7:0] C_DISP  = 8'h8F;

    // Command byte field positions
    localparam int CMD_KIND_HI    = 7;
    localparam int CMD_KIND_LO    = 6;
    localparam int DATA_READ_BIT  = 1;
    localparam int DATA_FIXED_BIT = 2;
    localparam int DISP_ON_BIT    = 3;
    localparam int BRIGHT_MSB     = 2;
    localparam int ADDR_MSB       = 3;

    localparam int RAM_DEPTH = 16;
    localparam int KEY_BITS  = 32;

    // Pin ordering inside the synchronizer bundle; only the first
    // EDGE_PINS pins (strobe and serial clock) need edge detection.
    localparam int PIN_COUNT = 3;
    localparam int EDGE_PINS = 2;
    localparam int PIN_CS    = 0;
    localparam int PIN_CLK   = 1;
    localparam int PIN_DIO   = 2;
    localparam logic [PIN_COUNT-1:0] PIN_PRESET = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_READ,
        ST_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        KIND_INVALID = 2'b00,
        KIND_DATA    = 2'b01,
        KIND_DISP    = 2'b10,
        KIND_ADDR    = 2'b11
    } cmd_kind_t;

    // Classify a command byte by its two top bits
    function automatic cmd_kind_t cmd_kind(input logic [7:0] b);
        return cmd_kind_t'(b[CMD_KIND_HI:CMD_KIND_LO]);
    endfunction

endpackage

// File: rtl/tm1638_pin_sync.sv
// Two-flop synchronizers for the TM1638 pins plus edge detection on strobe and clock.
module tm1638_pin_sync
    import tm1638_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIN_COUNT-1:0] pins,
    output logic [PIN_COUNT-1:0] level,
    output logic [EDGE_PINS-1:0] rise,
    output logic [EDGE_PINS-1:0] fall
);

    genvar gi;
    generate
        for (gi = 0; gi < PIN_COUNT; gi++) begin : g_pin
            logic meta_reg;
            logic sync_reg;

            // Double-flop the asynchronous pin; preset to the idle-high level
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= PIN_PRESET[gi];
                    sync_reg <= PIN_PRESET[gi];
                end else begin
                    meta_reg <= pins[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign level[gi] = sync_reg;

            if (gi < EDGE_PINS) begin : g_edge
                logic prev_reg;

                // Delayed copy of the synchronized level for edge detection
                always_ff @(posedge clk) begin
                    if (rst) begin
                        prev_reg <= PIN_PRESET[gi];
                    end else begin
                        prev_reg <= sync_reg;
                    end
                end

                assign rise[gi] = sync_reg & ~prev_reg;
                assign fall[gi] = ~sync_reg & prev_reg;
            end
        end
    endgenerate

endmodule

// File: rtl/tm1638_responder.sv
// TM1638-style serial slave: command decode, 16-byte display RAM, key-scan readout.
module tm1638_responder
    import tm1638_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tm_cs,
    input  logic        tm_clk,
    input  logic        tm_dio_in,
    output logic        tm_dio_out,
    output logic        tm_dio_oe,
    input  logic [31:0] keys,
    input  logic [3:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        disp_on,
    output logic [2:0]  brightness,
    output logic        wr_stb
);

    logic [PIN_COUNT-1:0] pin_level;
    logic [EDGE_PINS-1:0] pin_rise;
    logic [EDGE_PINS-1:0] pin_fall;

    tm1638_pin_sync u_pin_sync (
        .clk   (clk),
        .rst   (rst),
        .pins  ({tm_dio_in, tm_clk, tm_cs}),
        .level (pin_level),
        .rise  (pin_rise),
        .fall  (pin_fall)
    );

    logic cs_rise;
    logic cs_fall;
    logic clk_rise;
    logic clk_fall;
    logic dio_level;
    logic idle_pins;

    assign cs_rise   = pin_rise[PIN_CS];
    assign cs_fall   = pin_fall[PIN_CS];
    assign clk_rise  = pin_rise[PIN_CLK];
    assign clk_fall  = pin_fall[PIN_CLK];
    assign dio_level = pin_level[PIN_DIO];
    // Bus is idle when strobe and serial clock are both high
    assign idle_pins = pin_level[PIN_CS] & pin_level[PIN_CLK];

    state_t                state_reg;
    logic [2:0]            bit_cnt_reg;
    logic [7:0]            shift_reg;
    logic                  fixed_reg;
    logic [3:0]            addr_reg;
    logic [7:0]            ram_reg [RAM_DEPTH];
    logic                  disp_on_reg;
    logic [2:0]            bright_reg;
    logic                  wr_stb_reg;
    logic                  oe_reg;
    logic                  dout_reg;
    logic [KEY_BITS-1:0]   snap_reg;
    logic [4:0]            rd_cnt_reg;
    logic                  rd_active_reg;
    logic                  armed_reg;
    logic [1:0]            settle_reg;
    logic [7:0]            rd_data_reg;

    // Byte completed by the current rising edge (LSB arrives first)
    logic [7:0] rx_byte;
    assign rx_byte = {dio_level, shift_reg[7:1]};

    // Protocol FSM, display RAM writes and DIO driver
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            fixed_reg     <= 1'b0;
            addr_reg      <= 4'd0;
            for (int i = 0; i < RAM_DEPTH; i++) begin
                ram_reg[i] <= 8'h00;
            end
            disp_on_reg   <= 1'b0;
            bright_reg    <= 3'd0;
            wr_stb_reg    <= 1'b0;
            oe_reg        <= 1'b0;
            dout_reg      <= 1'b1;
            snap_reg      <= '0;
            rd_cnt_reg    <= 5'd0;
            rd_active_reg <= 1'b0;
            armed_reg     <= 1'b0;
            settle_reg    <= 2'd0;
        end else begin
            wr_stb_reg <= 1'b0;

            // Synchronizer outputs are meaningless until they have flushed
            // their preset values; only then may an idle bus arm us.
            if (settle_reg != 2'd3) begin
                settle_reg <= settle_reg + 2'd1;
            end
            if (cs_rise || (settle_reg == 2'd3 && idle_pins)) begin
                armed_reg <= 1'b1;
            end

            if (cs_rise) begin
                state_reg     <= ST_IDLE;
                bit_cnt_reg   <= 3'd0;
                oe_reg        <= 1'b0;
                dout_reg      <= 1'b1;
                rd_active_reg <= 1'b0;
            end else if (cs_fall && armed_reg) begin
                state_reg     <= ST_CMD;
                bit_cnt_reg   <= 3'd0;
                oe_reg        <= 1'b0;
                dout_reg      <= 1'b1;
                rd_active_reg <= 1'b0;
            end else begin
                unique case (state_reg)
                    ST_CMD: begin
                        if (clk_rise) begin
                            shift_reg   <= rx_byte;
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                unique case (cmd_kind(rx_byte))
                                    KIND_DATA: begin
                                        if (rx_byte[DATA_READ_BIT]) begin
                                            snap_reg      <= keys;
                                            rd_active_reg <= 1'b0;
                                            state_reg     <= ST_READ;
                                        end else begin
                                            fixed_reg <= rx_byte[DATA_FIXED_BIT];
                                            state_reg <= ST_IGNORE;
                                        end
                                    end
                                    KIND_ADDR: begin
                                        addr_reg  <= rx_byte[ADDR_MSB:0];
                                        state_reg <= ST_WRITE;
                                    end
                                    KIND_DISP: begin
                                        disp_on_reg <= rx_byte[DISP_ON_BIT];
                                        bright_reg  <= rx_byte[BRIGHT_MSB:0];
                                        state_reg   <= ST_IGNORE;
                                    end
                                    default: begin
                                        state_reg <= ST_IGNORE;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (clk_rise) begin
                            shift_reg   <= rx_byte;
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                ram_reg[addr_reg] <= rx_byte;
                                wr_stb_reg        <= 1'b1;
                                if (!fixed_reg) begin
                                    addr_reg <= addr_reg + 4'd1;
                                end
                            end
                        end
                    end
                    ST_READ: begin
                        // Bits change on falling edges so the host sees them
                        // stable at its rising edges.
                        if (clk_fall) begin
                            if (!rd_active_reg) begin
                                oe_reg        <= 1'b1;
                                dout_reg      <= snap_reg[0];
                                snap_reg      <= snap_reg >> 1;
                                rd_cnt_reg    <= 5'd0;
                                rd_active_reg <= 1'b1;
                            end else if (rd_cnt_reg == 5'd31) begin
                                oe_reg        <= 1'b0;
                                dout_reg      <= 1'b1;
                                rd_active_reg <= 1'b0;
                                state_reg     <= ST_IGNORE;
                            end else begin
                                dout_reg   <= snap_reg[0];
                                snap_reg   <= snap_reg >> 1;
                                rd_cnt_reg <= rd_cnt_reg + 5'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Registered read port for the display RAM
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= 8'h00;
        end else begin
            rd_data_reg <= ram_reg[rd_addr];
        end
    end

    assign tm_dio_out = dout_reg;
    assign tm_dio_oe  = oe_reg;
    assign rd_data    = rd_data_reg;
    assign disp_on    = disp_on_reg;
    assign brightness = bright_reg;
    assign wr_stb     = wr_stb_reg;

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench for tm1638_responder: host bit-banging tasks and a strobe-level model.
module tb_tm1638_responder;

    localparam int H = 6;  // half tm_clk period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        tm_cs;
    logic        tm_clk;
    logic        tm_dio_in;
    logic        tm_dio_out;
    logic        tm_dio_oe;
    logic [31:0] keys;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        disp_on;
    logic [2:0]  brightness;
    logic        wr_stb;

    tm1638_responder dut (
        .clk        (clk),
        .rst        (rst),
        .tm_cs      (tm_cs),
        .tm_clk     (tm_clk),
        .tm_dio_in  (tm_dio_in),
        .tm_dio_out (tm_dio_out),
        .tm_dio_oe  (tm_dio_oe),
        .keys       (keys),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .disp_on    (disp_on),
        .brightness (brightness),
        .wr_stb     (wr_stb)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;

    always @(posedge clk) begin
        if (wr_stb === 1'b1) wr_cnt = wr_cnt + 1;
    end

    // Behavioural model of what the display should hold
    logic [7:0] m_ram [16];
    logic       m_fixed;
    logic       m_disp;
    logic [2:0] m_bright;
    int         m_wr;

    logic [7:0] dut_ram [16];
    logic [7:0] tx_q [$];

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_fixed  = 1'b0;
        m_disp   = 1'b0;
        m_bright = 3'd0;
    endtask

    // Interpret one complete strobe's worth of bytes
    task automatic model_apply();
        logic [7:0] c;
        int a;
        c = tx_q[0];
        if (c[7:6] == 2'b01 && c[1] == 1'b0) begin
            m_fixed = c[2];
        end else if (c[7:6] == 2'b10) begin
            m_disp   = c[3];
            m_bright = c[2:0];
        end else if (c[7:6] == 2'b11) begin
            a = int'(c[3:0]);
            for (int i = 1; i < tx_q.size(); i++) begin
                m_ram[a] = tx_q[i];
                m_wr = m_wr + 1;
                if (!m_fixed) a = (a + 1) % 16;
            end
        end
    endtask

    task automatic host_bit(input logic b);
        tm_clk = 1'b0;
        tm_dio_in = b;
        wait_cyc(H);
        tm_clk = 1'b1;
        wait_cyc(H);
    endtask

    task automatic host_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) host_bit(b[i]);
    endtask

    task automatic do_strobe();
        tm_cs = 1'b0;
        wait_cyc(H);
        for (int i = 0; i < tx_q.size(); i++) host_byte(tx_q[i]);
        wait_cyc(H);
        tm_cs = 1'b1;
        tm_dio_in = 1'b1;
        wait_cyc(2 * H);
        model_apply();
        $display("strobe: %0d bytes, first %h", tx_q.size(), tx_q[0]);
    endtask

    task automatic dump_ram();
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            wait_cyc(1);
            dut_ram[i] = rd_data;
        end
    endtask

    // Host read of 32 key bits; keys change to keys_late after bit 5
    task automatic do_read(input logic [31:0] keys_late, output logic [31:0] got,
                           output int oe_bad, output logic oe_after);
        got = '0;
        oe_bad = 0;
        tm_cs = 1'b0;
        wait_cyc(H);
        host_byte(8'h42);
        tm_dio_in = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tm_clk = 1'b0;
            wait_cyc(H);
            got[i] = tm_dio_out;
            if (tm_dio_oe !== 1'b1) oe_bad++;
            if (i == 5) keys = keys_late;
            tm_clk = 1'b1;
            wait_cyc(H);
        end
        tm_clk = 1'b0;
        wait_cyc(H);
        oe_after = tm_dio_oe;
        tm_clk = 1'b1;
        wait_cyc(H);
        tm_cs = 1'b1;
        wait_cyc(2 * H);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(1);
        model_reset();
        checks++; if (tm_dio_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", tm_dio_oe); end
        checks++; if (tm_dio_out !== 1'b1) begin errors++; $display("FAIL reset_dout got %b want 1", tm_dio_out); end
        checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL reset_disp got %b want 0", disp_on); end
        checks++; if (brightness !== 3'd0) begin errors++; $display("FAIL reset_bright got %0d want 0", brightness); end
        checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_wrstb got %b want 0", wr_stb); end
        dump_ram();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut_ram[i] !== 8'h00) begin errors++; $display("FAIL reset_ram[%0d] got %h want 00", i, dut_ram[i]); end
        end
        $display("reset: done");
    endtask

    task automatic test_write_burst();
        int w0;
        w0 = wr_cnt;
        tx_q.delete(); tx_q.push_back(8'h40); do_strobe();
        tx_q.delete(); tx_q.push_back(8'hC0); tx_q.push_back(8'h3F); tx_q.push_back(8'h06); do_strobe();
        dump_ram();
        checks++; if (dut_ram[0] !== 8'h3F) begin errors++; $display("FAIL burst_ram0 got %h want 3f", dut_ram[0]); end
        checks++; if (dut_ram[1] !== 8'h06) begin errors++; $display("FAIL burst_ram1 got %h want 06", dut_ram[1]); end
        checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL burst_wrstb got %0d want 2", wr_cnt - w0); end
    endtask

    task automatic test_fixed_wrap();
        for (int pass = 0; pass < 2; pass++) begin
            tx_q.delete(); tx_q.push_back(pass == 0 ? 8'h44 : 8'h40); do_strobe();
            tx_q.delete(); tx_q.push_back(8'hCF); tx_q.push_back(8'h11); tx_q.push_back(8'h22); do_strobe();
            dump_ram();
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (dut_ram[i] !== m_ram[i]) begin errors++; $display("FAIL wrap%0d_ram[%0d] got %h want %h", pass, i, dut_ram[i], m_ram[i]); end
            end
        end
        checks++; if (dut_ram[15] !== 8'h11 || dut_ram[0] !== 8'h22) begin
            errors++; $display("FAIL wrap_auto got %h/%h want 11/22", dut_ram[15], dut_ram[0]);
        end
    endtask

    task automatic test_random_writes();
        int w0, mw0, n;
        logic [7:0] b;
        for (int it = 0; it < 6; it++) begin
            w0 = wr_cnt;
            mw0 = m_wr;
            b = 8'h40 | (8'($urandom_range(0, 1)) << 2);
            tx_q.delete(); tx_q.push_back(b); do_strobe();
            n = $urandom_range(1, 5);
            tx_q.delete(); tx_q.push_back(8'hC0 | 8'($urandom_range(0, 15)));
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            do_strobe();
            dump_ram();
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (dut_ram[i] !== m_ram[i]) begin errors++; $display("FAIL rand%0d_ram[%0d] got %h want %h", it, i, dut_ram[i], m_ram[i]); end
            end
            checks++; if (wr_cnt - w0 !== m_wr - mw0) begin errors++; $display("FAIL rand%0d_wrstb got %0d want %0d", it, wr_cnt - w0, m_wr - mw0); end
        end
    endtask

    task automatic test_display();
        tx_q.delete(); tx_q.push_back(8'h8F); do_strobe();
        checks++; if (disp_on !== 1'b1 || brightness !== 3'd7) begin errors++; $display("FAIL disp_8f got %b/%0d want 1/7", disp_on, brightness); end
        tx_q.delete(); tx_q.push_back(8'h80); do_strobe();
        checks++; if (disp_on !== 1'b0 || brightness !== 3'd0) begin errors++; $display("FAIL disp_80 got %b/%0d want 0/0", disp_on, brightness); end
        for (int it = 0; it < 6; it++) begin
            // alternate display-control and invalid (top bits 00) commands
            tx_q.delete();
            tx_q.push_back({(it % 2 == 0) ? 2'b10 : 2'b00, 6'($urandom)});
            do_strobe();
            checks++;
            if (disp_on !== m_disp || brightness !== m_bright) begin
                errors++; $display("FAIL disp_rand%0d got %b/%0d want %b/%0d", it, disp_on, brightness, m_disp, m_bright);
            end
        end
    endtask

    task automatic test_key_read();
        logic [31:0] got, k0;
        int oe_bad;
        logic oe_after;
        for (int it = 0; it < 3; it++) begin
            k0 = (it == 0) ? 32'h0110_0001 : $urandom;
            keys = k0;
            do_read(~k0, got, oe_bad, oe_after);
            $display("read %0d: keys %h received %h", it, k0, got);
            checks++; if (got !== k0) begin errors++; $display("FAIL read%0d_data got %h want %h", it, got, k0); end
            checks++; if (oe_bad !== 0) begin errors++; $display("FAIL read%0d_oe_low got %0d bits want 0", it, oe_bad); end
            checks++; if (oe_after !== 1'b0) begin errors++; $display("FAIL read%0d_release got %b want 0", it, oe_after); end
        end
    endtask

    task automatic test_abort();
        int w0, rel;
        w0 = wr_cnt;
        // partial address byte 0xC3, 5 bits
        tm_cs = 1'b0; wait_cyc(H);
        for (int i = 0; i < 5; i++) host_bit(((8'hC3 >> i) & 8'h01) != 0);
        tm_cs = 1'b1; tm_dio_in = 1'b1; wait_cyc(2 * H);
        // partial data byte after a valid address byte
        tm_cs = 1'b0; wait_cyc(H);
        host_byte(8'hC5);
        for (int i = 0; i < 4; i++) host_bit(1'b0);
        tm_cs = 1'b1; tm_dio_in = 1'b1; wait_cyc(2 * H);
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL abort_wrstb got %0d want %0d", wr_cnt - w0, 0); end
        dump_ram();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut_ram[i] !== m_ram[i]) begin errors++; $display("FAIL abort_ram[%0d] got %h want %h", i, dut_ram[i], m_ram[i]); end
        end
        // abort a read in progress
        keys = $urandom;
        tm_cs = 1'b0; wait_cyc(H);
        host_byte(8'h42);
        tm_dio_in = 1'b1;
        for (int i = 0; i < 10; i++) host_bit(1'b1);
        tm_clk = 1'b0; wait_cyc(H);
        checks++; if (tm_dio_oe !== 1'b1) begin errors++; $display("FAIL abort_read_driving got %b want 1", tm_dio_oe); end
        tm_cs = 1'b1;
        rel = 0;
        for (int k = 1; k <= 6; k++) begin
            wait_cyc(1);
            if (rel == 0 && tm_dio_oe === 1'b0) rel = k;
        end
        checks++; if (rel == 0 || rel > 4) begin errors++; $display("FAIL abort_read_release got %0d cycles want 1..4", rel); end
        tm_clk = 1'b1; wait_cyc(2 * H);
        $display("abort: read released after %0d cycles", rel);
    endtask

    task automatic test_reset_mid_read();
        int w0;
        keys = $urandom;
        tm_cs = 1'b0; wait_cyc(H);
        host_byte(8'h42);
        tm_dio_in = 1'b1;
        for (int i = 0; i < 12; i++) host_bit(1'b1);
        tm_clk = 1'b0; wait_cyc(H);
        checks++; if (tm_dio_oe !== 1'b1) begin errors++; $display("FAIL rstread_driving got %b want 1", tm_dio_oe); end
        rst = 1'b1;
        wait_cyc(1);
        checks++; if (tm_dio_oe !== 1'b0 || tm_dio_out !== 1'b1) begin
            errors++; $display("FAIL rstread_release got oe=%b out=%b want 0/1", tm_dio_oe, tm_dio_out);
        end
        rst = 1'b0;
        model_reset();
        dump_ram();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut_ram[i] !== 8'h00) begin errors++; $display("FAIL rstread_ram[%0d] got %h want 00", i, dut_ram[i]); end
        end
        // strobe still low: clock activity must be ignored
        w0 = wr_cnt;
        for (int i = 0; i < 16; i++) host_bit(1'($urandom));
        tm_cs = 1'b1; tm_dio_in = 1'b1; wait_cyc(2 * H);
        checks++; if (wr_cnt !== w0 || tm_dio_oe !== 1'b0) begin
            errors++; $display("FAIL rstread_ignore got wr=%0d oe=%b want 0/0", wr_cnt - w0, tm_dio_oe);
        end
        // normal operation resumes in auto-increment mode
        tx_q.delete(); tx_q.push_back(8'hC7); tx_q.push_back(8'h99); tx_q.push_back(8'h5A); do_strobe();
        dump_ram();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut_ram[i] !== m_ram[i]) begin errors++; $display("FAIL rstread_after_ram[%0d] got %h want %h", i, dut_ram[i], m_ram[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        tm_cs = 1'b1;
        tm_clk = 1'b1;
        tm_dio_in = 1'b1;
        keys = '0;
        rd_addr = 4'd0;
        m_wr = 0;
        test_reset();
        test_write_burst();
        test_fixed_wrap();
        test_random_writes();
        test_display();
        test_key_read();
        test_abort();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
